// File: rtl/baccarat_dealer_fsm.sv
// Baccarat dealing controller: sequences card-load strobes, applies the
// natural / player / banker third-card rules, registers the winner lights
// and keeps saturating win/tie tallies.
module baccarat_dealer_fsm #(
  parameter int unsigned CNT_W     = 8,
  parameter bit          AUTO_DEAL = 1'b0
) (
  input  logic             slow_clock,
  input  logic             resetb,
  input  logic             start,
  input  logic [3:0]       pscore,
  input  logic [3:0]       dscore,
  input  logic [3:0]       pcard3,
  output logic             load_pcard1,
  output logic             load_pcard2,
  output logic             load_pcard3,
  output logic             load_dcard1,
  output logic             load_dcard2,
  output logic             load_dcard3,
  output logic             player_win_light,
  output logic             dealer_win_light,
  output logic             done,
  output logic [CNT_W-1:0] player_wins,
  output logic [CNT_W-1:0] dealer_wins,
  output logic [CNT_W-1:0] ties
);

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_P1     = 4'd1,
    S_D1     = 4'd2,
    S_P2     = 4'd3,
    S_D2     = 4'd4,
    S_CHECK  = 4'd5,
    S_P3     = 4'd6,
    S_BANK   = 4'd7,
    S_D3     = 4'd8,
    S_RESULT = 4'd9,
    S_DONE   = 4'd10
  } state_t;

  localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           state_q, state_d;
  logic             plight_q, plight_d;
  logic             dlight_q, dlight_d;
  logic [CNT_W-1:0] pw_q, pw_d;
  logic [CNT_W-1:0] dw_q, dw_d;
  logic [CNT_W-1:0] ti_q, ti_d;

  logic [3:0] ps, ds, v;
  logic       bank_draw;

  // Sanitise datapath inputs: scores above 9 stand as 9, face/illegal ranks count 0
  always_comb begin
    ps = (pscore > 4'd9) ? 4'd9 : pscore;
    ds = (dscore > 4'd9) ? 4'd9 : dscore;
    v  = (pcard3 >= 4'd1 && pcard3 <= 4'd9) ? pcard3 : 4'd0;
  end

  // Banker third-card table indexed by dealer score and player third-card value
  always_comb begin
    bank_draw = 1'b0;
    case (ds)
      4'd0, 4'd1, 4'd2: bank_draw = 1'b1;
      4'd3:             bank_draw = (v != 4'd8);
      4'd4:             bank_draw = (v >= 4'd2) && (v <= 4'd7);
      4'd5:             bank_draw = (v >= 4'd4) && (v <= 4'd7);
      4'd6:             bank_draw = (v >= 4'd6) && (v <= 4'd7);
      default:          bank_draw = 1'b0;
    endcase
  end

  // State register
  always_ff @(posedge slow_clock or negedge resetb) begin
    if (!resetb) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (start || AUTO_DEAL) state_d = S_P1;
      S_P1:     state_d = S_D1;
      S_D1:     state_d = S_P2;
      S_P2:     state_d = S_D2;
      S_D2:     state_d = S_CHECK;
      S_CHECK: begin
        if (ps >= 4'd8 || ds >= 4'd8) state_d = S_RESULT;
        else if (ps <= 4'd5)          state_d = S_P3;
        else if (ds <= 4'd5)          state_d = S_D3;
        else                          state_d = S_RESULT;
      end
      S_P3:     state_d = S_BANK;
      S_BANK:   state_d = bank_draw ? S_D3 : S_RESULT;
      S_D3:     state_d = S_RESULT;
      S_RESULT: state_d = S_DONE;
      S_DONE:   if (start) state_d = S_P1;
      default:  state_d = S_IDLE;
    endcase
  end

  // Moore strobe decode from the registered state
  always_comb begin
    load_pcard1 = (state_q == S_P1);
    load_dcard1 = (state_q == S_D1);
    load_pcard2 = (state_q == S_P2);
    load_dcard2 = (state_q == S_D2);
    load_pcard3 = (state_q == S_P3);
    load_dcard3 = (state_q == S_D3);
    done        = (state_q == S_DONE);
  end

  // Result capture: lights and tallies update leaving RESULT, lights clear entering P1
  always_comb begin
    plight_d = plight_q;
    dlight_d = dlight_q;
    pw_d     = pw_q;
    dw_d     = dw_q;
    ti_d     = ti_q;
    if (state_q == S_RESULT) begin
      if (ps > ds) begin
        plight_d = 1'b1;
        dlight_d = 1'b0;
        pw_d     = (pw_q == '1) ? pw_q : pw_q + ONE;
      end else if (ds > ps) begin
        plight_d = 1'b0;
        dlight_d = 1'b1;
        dw_d     = (dw_q == '1) ? dw_q : dw_q + ONE;
      end else begin
        plight_d = 1'b1;
        dlight_d = 1'b1;
        ti_d     = (ti_q == '1) ? ti_q : ti_q + ONE;
      end
    end else if (state_d == S_P1) begin
      plight_d = 1'b0;
      dlight_d = 1'b0;
    end
  end

  // Light and tally registers
  always_ff @(posedge slow_clock or negedge resetb) begin
    if (!resetb) begin
      plight_q <= 1'b0;
      dlight_q <= 1'b0;
      pw_q     <= '0;
      dw_q     <= '0;
      ti_q     <= '0;
    end else begin
      plight_q <= plight_d;
      dlight_q <= dlight_d;
      pw_q     <= pw_d;
      dw_q     <= dw_d;
      ti_q     <= ti_d;
    end
  end

  assign player_win_light = plight_q;
  assign dealer_win_light = dlight_q;
  assign player_wins      = pw_q;
  assign dealer_wins      = dw_q;
  assign ties             = ti_q;

endmodule

// File: tb/tb_baccarat_dealer_fsm.sv
// Scoreboard bench for baccarat_dealer_fsm: a driver plays directed hands and
// queues the expected outcome; monitors pop and compare on each rising done.
module tb_baccarat_dealer_fsm;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Instance A: default parameters
  logic       rst_n = 1'b0, start = 1'b0;
  logic [3:0] pscore = '0, dscore = '0, pcard3 = '0;
  logic lp1, lp2, lp3, ld1, ld2, ld3, pl, dl, done;
  logic [7:0] pw, dw, ti;

  baccarat_dealer_fsm #(.CNT_W(8), .AUTO_DEAL(1'b0)) dut (
    .slow_clock(clk), .resetb(rst_n), .start(start),
    .pscore(pscore), .dscore(dscore), .pcard3(pcard3),
    .load_pcard1(lp1), .load_pcard2(lp2), .load_pcard3(lp3),
    .load_dcard1(ld1), .load_dcard2(ld2), .load_dcard3(ld3),
    .player_win_light(pl), .dealer_win_light(dl), .done(done),
    .player_wins(pw), .dealer_wins(dw), .ties(ti)
  );

  // Instance B: 2-bit tallies, auto-deal
  logic       rst_b = 1'b0, start_b = 1'b0;
  logic [3:0] ps_b = 4'd9, ds_b = 4'd0, c3_b = 4'd1;
  logic lp1_b, lp2_b, lp3_b, ld1_b, ld2_b, ld3_b, pl_b, dl_b, done_b;
  logic [1:0] pw_b, dw_b, ti_b;

  baccarat_dealer_fsm #(.CNT_W(2), .AUTO_DEAL(1'b1)) dut_b (
    .slow_clock(clk), .resetb(rst_b), .start(start_b),
    .pscore(ps_b), .dscore(ds_b), .pcard3(c3_b),
    .load_pcard1(lp1_b), .load_pcard2(lp2_b), .load_pcard3(lp3_b),
    .load_dcard1(ld1_b), .load_dcard2(ld2_b), .load_dcard3(ld3_b),
    .player_win_light(pl_b), .dealer_win_light(dl_b), .done(done_b),
    .player_wins(pw_b), .dealer_wins(dw_b), .ties(ti_b)
  );

  typedef struct packed {
    logic [3:0] p0, d0, c3, pf, df;
    logic [5:0] mask;   // {ld3,lp3,ld2,lp2,ld1,lp1}
    logic [1:0] win;    // 0 player, 1 dealer, 2 tie
  } hand_t;

  typedef struct packed {
    logic [5:0] mask;
    logic       pl, dl;
    logic [7:0] pw, dw, ti;
  } exp_t;

  exp_t       qa[$];
  logic [1:0] qb[$];
  int tests = 0, fails = 0;
  int m_pw = 0, m_dw = 0, m_ti = 0;
  hand_t hv[14];

  task automatic check(input string name, input int act, input int req);
    tests++;
    if (act != req) begin
      fails++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  // Monitor A: lights must be clear entering P1; compare outcome on done rise
  logic [5:0] mask_a = '0;
  logic       dprev_a = 1'b0;
  always @(negedge clk) begin
    if (!rst_n) begin
      mask_a  = '0;
      dprev_a = 1'b0;
    end else begin
      if (lp1) begin
        check("lights_clear_p1", {30'd0, pl, dl}, 0);
        check("done_clear_p1", {31'd0, done}, 0);
        mask_a = '0;
      end
      mask_a |= {ld3, lp3, ld2, lp2, ld1, lp1};
      if (done && !dprev_a) begin
        if (qa.size() == 0) begin
          check("unexpected_done", 1, 0);
        end else begin
          exp_t e;
          e = qa.pop_front();
          check("strobe_mask", {26'd0, mask_a}, {26'd0, e.mask});
          check("player_light", {31'd0, pl}, {31'd0, e.pl});
          check("dealer_light", {31'd0, dl}, {31'd0, e.dl});
          check("player_wins", {24'd0, pw}, {24'd0, e.pw});
          check("dealer_wins", {24'd0, dw}, {24'd0, e.dw});
          check("ties", {24'd0, ti}, {24'd0, e.ti});
        end
      end
      dprev_a = done;
    end
  end

  // Monitor B: saturating player tally on each done rise
  logic dprev_b = 1'b0;
  always @(negedge clk) begin
    if (!rst_b) begin
      dprev_b = 1'b0;
    end else begin
      if (done_b && !dprev_b) begin
        if (qb.size() == 0) begin
          check("unexpected_done_b", 1, 0);
        end else begin
          logic [1:0] e;
          e = qb.pop_front();
          check("sat_player_wins", {30'd0, pw_b}, {30'd0, e});
          check("sat_dealer_wins", {30'd0, dw_b}, 0);
          check("sat_ties", {30'd0, ti_b}, 0);
        end
      end
      dprev_b = done_b;
    end
  end

  task automatic push_exp(input hand_t h);
    exp_t e;
    case (h.win)
      2'd0:    begin m_pw++; e.pl = 1'b1; e.dl = 1'b0; end
      2'd1:    begin m_dw++; e.pl = 1'b0; e.dl = 1'b1; end
      default: begin m_ti++; e.pl = 1'b1; e.dl = 1'b1; end
    endcase
    e.mask = h.mask;
    e.pw   = 8'(m_pw);
    e.dw   = 8'(m_dw);
    e.ti   = 8'(m_ti);
    qa.push_back(e);
  endtask

  // Emulates the datapath: third cards change the score from the next cycle
  task automatic finish_hand(input hand_t h);
    for (int i = 0; i < 20; i++) begin
      if (lp3) pscore = h.pf;
      if (ld3) dscore = h.df;
      if (done) break;
      @(negedge clk);
    end
    if (!done) check("hand_timeout", 0, 1);
  endtask

  task automatic run_hand(input hand_t h);
    push_exp(h);
    pscore = h.p0; dscore = h.d0; pcard3 = h.c3;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    finish_hand(h);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    //          p0     d0     c3     pf     df     mask   win
    hv[0]  = '{4'd8, 4'd3, 4'd5, 4'd8, 4'd3, 6'h0F, 2'd0}; // natural, player
    hv[1]  = '{4'd4, 4'd3, 4'd8, 4'd2, 4'd3, 6'h1F, 2'd1}; // bank 3 v=8 stands
    hv[2]  = '{4'd4, 4'd3, 4'd12,4'd4, 4'd9, 6'h3F, 2'd1}; // bank 3 v=0 draws
    hv[3]  = '{4'd7, 4'd5, 4'd1, 4'd7, 4'd9, 6'h2F, 2'd1}; // player stands, dealer draws
    hv[4]  = '{4'd6, 4'd6, 4'd1, 4'd6, 4'd6, 6'h0F, 2'd2}; // both stand, tie
    hv[5]  = '{4'd0, 4'd4, 4'd2, 4'd2, 4'd7, 6'h3F, 2'd1}; // bank 4 v=2 draws
    hv[6]  = '{4'd5, 4'd6, 4'd6, 4'd1, 4'd8, 6'h3F, 2'd1}; // bank 6 v=6 draws
    hv[7]  = '{4'd3, 4'd7, 4'd7, 4'd0, 4'd7, 6'h1F, 2'd1}; // bank 7 never
    hv[8]  = '{4'd15,4'd4, 4'd1, 4'd15,4'd4, 6'h0F, 2'd0}; // illegal 15 = natural 9
    hv[9]  = '{4'd5, 4'd5, 4'd0, 4'd5, 4'd5, 6'h1F, 2'd2}; // bank 5 v=0 stands, tie
    hv[10] = '{4'd2, 4'd5, 4'd4, 4'd6, 4'd8, 6'h3F, 2'd1}; // bank 5 v=4 draws
    hv[11] = '{4'd6, 4'd9, 4'd1, 4'd6, 4'd9, 6'h0F, 2'd1}; // dealer natural
    hv[12] = '{4'd1, 4'd3, 4'd14,4'd1, 4'd0, 6'h3F, 2'd0}; // rank 14 = v0, player
    hv[13] = '{4'd4, 4'd2, 4'd8, 4'd2, 4'd1, 6'h3F, 2'd0}; // bank 2 always draws

    repeat (2) @(negedge clk);
    check("reset_done", {31'd0, done}, 0);
    check("reset_lights", {30'd0, pl, dl}, 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_no_autodeal", {31'd0, lp1}, 0);

    for (int i = 0; i < 14; i++) run_hand(hv[i]);

    // Abort a hand in D1 with asynchronous reset
    pscore = 4'd9; dscore = 4'd2; pcard3 = 4'd1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 5 && !ld1; i++) @(negedge clk);
    check("reached_d1", {31'd0, ld1}, 1);
    rst_n = 1'b0;
    #1;
    check("rst_loads", {26'd0, ld3, lp3, ld2, lp2, ld1, lp1}, 0);
    check("rst_lights_done", {29'd0, pl, dl, done}, 0);
    check("rst_tallies", {8'd0, pw, dw, ti}, 0);
    m_pw = 0; m_dw = 0; m_ti = 0;
    @(negedge clk);
    push_exp(hv[8]);
    pscore = 4'd9; dscore = 4'd2;
    start = 1'b1;
    rst_n = 1'b1;
    @(negedge clk);
    check("p1_after_reset", {31'd0, lp1}, 1);
    start = 1'b0;
    begin
      hand_t h;
      h = '{4'd9, 4'd2, 4'd1, 4'd9, 4'd2, 6'h0F, 2'd0};
      finish_hand(h);
    end

    // Auto-deal and saturation on instance B
    check("b_idle_in_reset", {31'd0, lp1_b}, 0);
    qb.push_back(2'd1);
    rst_b = 1'b1;
    #1;
    check("b_no_p1_release_cycle", {31'd0, lp1_b}, 0);
    @(negedge clk);
    check("b_autodeal_p1", {31'd0, lp1_b}, 1);
    for (int i = 0; i < 12 && !done_b; i++) @(negedge clk);
    check("b_done_reached", {31'd0, done_b}, 1);
    repeat (3) @(negedge clk);
    check("b_done_holds_without_start", {31'd0, done_b}, 1);
    for (int n = 2; n <= 5; n++) begin
      qb.push_back((n > 3) ? 2'd3 : 2'(n));
      start_b = 1'b1;
      @(negedge clk);
      start_b = 1'b0;
      for (int i = 0; i < 12 && !done_b; i++) @(negedge clk);
      check("b_hand_done", {31'd0, done_b}, 1);
    end

    repeat (2) @(negedge clk);
    check("queue_a_drained", qa.size(), 0);
    check("queue_b_drained", qb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
